sec_codeword_assembler: RTL and testbench

//  Byte-serial front end for the 32-bit single-error-correcting datapath.

---
 rtl/sec_codeword_assembler.sv | 121 ++++++++++++
 tb/tb_sec_codeword_assembler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sec_codeword_assembler.sv
// Byte-serial front end for the 32-bit SEC datapath: gathers 4 data bytes plus an
// optional check byte into one registered codeword; malformed frames are dropped and counted.
module sec_codeword_assembler #(
  parameter int ERR_CNT_W     = 8,
  parameter bit REQUIRE_CHECK = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:31]          out_id,
  output logic [0:7]           out_ic,
  output logic                 out_r,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count
);

  typedef enum logic {S_COLLECT, S_DISCARD} state_t;

  state_t               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [0:31]          acc_q, acc_d;
  logic                 valid_q, valid_d;
  logic [0:31]          id_q;
  logic [0:7]           ic_q;
  logic                 r_q;
  logic                 ferr_q;
  logic [ERR_CNT_W-1:0] errc_q;

  logic                 accept, done, bad;
  logic [0:31]          new_id;
  logic [0:7]           new_ic;
  logic                 new_r;

  // Only the byte that could complete a frame waits for the output slot to free up.
  assign in_ready = (state_q == S_DISCARD) | (cnt_q < 3'd3) | ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    done    = 1'b0;
    bad     = 1'b0;
    new_id  = acc_q;
    new_ic  = '0;
    new_r   = 1'b0;
    if (accept) begin
      if (state_q == S_DISCARD) begin
        if (in_last) begin
          bad     = 1'b1;
          cnt_d   = '0;
          state_d = S_COLLECT;
        end
      end else if (in_last) begin
        cnt_d = '0;
        unique case (cnt_q)
          3'd3: begin
            if (REQUIRE_CHECK) bad = 1'b1;
            else begin
              done   = 1'b1;
              new_id = {acc_q[8:31], in_data};
            end
          end
          3'd4: begin
            done   = 1'b1;
            new_ic = in_data;
            new_r  = 1'b1;
          end
          default: bad = 1'b1;
        endcase
      end else if (cnt_q == 3'd5) begin
        state_d = S_DISCARD;
      end else begin
        // Data bytes shift in MSB-first; a fifth byte only advances the count.
        if (cnt_q < 3'd4) acc_d = {acc_q[8:31], in_data};
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  assign valid_d = done | (valid_q & ~out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      ic_q    <= '0;
      r_q     <= 1'b0;
      ferr_q  <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      ferr_q  <= bad;
      if (done) begin
        id_q <= new_id;
        ic_q <= new_ic;
        r_q  <= new_r;
      end
      if (bad && (errc_q != '1)) errc_q <= errc_q + 1'b1;
    end
  end

  assign out_valid = valid_q;
  assign out_id    = id_q;
  assign out_ic    = ic_q;
  assign out_r     = r_q;
  assign frame_err = ferr_q;
  assign err_count = errc_q;

endmodule

// File: tb/tb_sec_codeword_assembler.sv
// Directed and randomized checks of sec_codeword_assembler against a frame-level model.
module tb_sec_codeword_assembler;

  logic        clk, rst_n;
  logic        in_valid, in_last, out_ready, sel;
  logic [7:0]  in_data;

  logic        a_in_ready, a_out_valid, a_out_r, a_frame_err;
  logic [0:31] a_out_id;
  logic [0:7]  a_out_ic;
  logic [7:0]  a_err_count;

  logic        b_in_ready, b_out_valid, b_out_r, b_frame_err;
  logic [0:31] b_out_id;
  logic [0:7]  b_out_ic;
  logic [1:0]  b_err_count;

  logic        a_in_valid, b_in_valid, cur_ready;
  assign a_in_valid = in_valid & ~sel;
  assign b_in_valid = in_valid & sel;
  assign cur_ready  = sel ? b_in_ready : a_in_ready;

  sec_codeword_assembler u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_id(a_out_id), .out_ic(a_out_ic), .out_r(a_out_r),
    .frame_err(a_frame_err), .err_count(a_err_count)
  );

  sec_codeword_assembler #(.ERR_CNT_W(2), .REQUIRE_CHECK(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_id(b_out_id), .out_ic(b_out_ic), .out_r(b_out_r),
    .frame_err(b_frame_err), .err_count(b_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          pulses = 0;
  int          exp_errs;
  bit          mon_en = 1'b0;
  bit          hold_prev = 1'b0;
  logic [41:0] prev_w;
  logic [7:0]  frm[$];
  logic [40:0] exp_q[$];
  logic [40:0] got_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor on DUT A: records delivered words, counts error pulses, checks hold stability.
  always @(negedge clk) begin
    if (!rst_n || !mon_en) hold_prev = 1'b0;
    else begin
      if (hold_prev) begin
        checks++;
        assert ({a_out_valid, a_out_id, a_out_ic, a_out_r} === prev_w) else begin
          errors++;
          $error("FAIL hold_stable got=%0h exp=%0h", {a_out_valid, a_out_id, a_out_ic, a_out_r}, prev_w);
        end
      end
      if (a_out_valid && out_ready) got_q.push_back({a_out_id, a_out_ic, a_out_r});
      if (a_frame_err) pulses++;
      hold_prev = a_out_valid && !out_ready;
      prev_w    = {1'b1, a_out_id, a_out_ic, a_out_r};
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last, input int rdy);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int g = 0; g < 500 && !acc; g++) begin
      out_ready = (rdy >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy);
      @(negedge clk);
      acc = cur_ready;
      @(posedge clk); #1;
    end
    chk("byte_accepted", {63'd0, acc}, 64'd1);
  endtask

  task automatic send_frame(input int rdy);
    for (int i = 0; i < frm.size(); i++) send_byte(frm[i], i == frm.size() - 1, rdy);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Frame-level reference: 5 bytes -> word+check, 4 bytes -> word only, anything else is an error.
  task automatic model_frame();
    if (frm.size() == 5)      exp_q.push_back({frm[0], frm[1], frm[2], frm[3], frm[4], 1'b1});
    else if (frm.size() == 4) exp_q.push_back({frm[0], frm[1], frm[2], frm[3], 8'h00, 1'b0});
    else                      exp_errs++;
  endtask

  initial begin
    rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    #3;
    chk("rst_in_ready",  {63'd0, a_in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    chk("rst_out_id",    {32'd0, a_out_id}, 64'd0);
    chk("rst_out_ic_r",  {55'd0, a_out_ic, a_out_r}, 64'd0);
    chk("rst_ferr_cnt",  {55'd0, a_frame_err, a_err_count}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1; mon_en = 1'b1;

    // 5-byte frame
    frm = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hA5}; send_frame(100);
    chk("t1_valid", {63'd0, a_out_valid}, 64'd1);
    chk("t1_id",    {32'd0, a_out_id}, 64'hDEADBEEF);
    chk("t1_id0",   {63'd0, a_out_id[0]}, 64'd1);
    chk("t1_ic_r",  {55'd0, a_out_ic, a_out_r}, {55'd0, 8'hA5, 1'b1});

    // 4-byte frame without check byte
    frm = '{8'h01, 8'h02, 8'h03, 8'h04}; send_frame(100);
    chk("t2_valid", {63'd0, a_out_valid}, 64'd1);
    chk("t2_id",    {32'd0, a_out_id}, 64'h01020304);
    chk("t2_ic_r",  {55'd0, a_out_ic, a_out_r}, 64'd0);
    @(posedge clk); #1;

    // Backpressure: held word, stalled completion byte, drain+load with no bubble
    got_q.delete();
    frm = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}; send_frame(0);
    send_byte(8'h66, 1'b0, 0); send_byte(8'h77, 1'b0, 0); send_byte(8'h88, 1'b0, 0);
    in_valid = 1'b1; in_data = 8'h99; in_last = 1'b1;
    @(negedge clk);
    chk("t3_stall",     {63'd0, a_in_ready}, 64'd0);
    chk("t3_held_id",   {32'd0, a_out_id}, 64'h11223344);
    @(posedge clk); @(negedge clk);
    chk("t3_stall2",    {63'd0, a_in_ready}, 64'd0);
    chk("t3_held_ic_r", {55'd0, a_out_valid, a_out_ic, a_out_r}, {55'd0, 1'b1, 8'h55, 1'b1});
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("t3_ready", {63'd0, a_in_ready}, 64'd1);
    @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    chk("t3_nobubble", {63'd0, a_out_valid}, 64'd1);
    chk("t3_new_id",   {32'd0, a_out_id}, 64'h66778899);
    chk("t3_new_r",    {55'd0, a_out_ic, a_out_r}, 64'd0);
    @(posedge clk); #1;
    chk("t3_drained", {63'd0, a_out_valid}, 64'd0);
    chk("t3_count",   got_q.size(), 64'd2);
    if (got_q.size() == 2) begin
      chk("t3_first",  {23'd0, got_q[0]}, {23'd0, 32'h11223344, 8'h55, 1'b1});
      chk("t3_second", {23'd0, got_q[1]}, {23'd0, 32'h66778899, 8'h00, 1'b0});
    end

    // Short frame, long frame, then a good frame
    pulses = 0;
    frm = '{8'hAA, 8'hBB}; send_frame(100);
    chk("t4_short_err", {55'd0, a_frame_err, a_err_count}, {55'd0, 1'b1, 8'd1});
    @(posedge clk); #1;
    chk("t4_pulse_end", {63'd0, a_frame_err}, 64'd0);
    frm = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16}; send_frame(100);
    chk("t4_long_err", {55'd0, a_frame_err, a_err_count}, {55'd0, 1'b1, 8'd2});
    @(posedge clk); #1;
    chk("t4_pulses", pulses, 64'd2);
    frm = '{8'hC0, 8'hFF, 8'hEE, 8'h01, 8'h02}; send_frame(100);
    chk("t4_good_id", {32'd0, a_out_id}, 64'hC0FFEE01);
    chk("t4_good_ic", {54'd0, a_out_valid, a_out_ic, a_out_r}, {54'd0, 1'b1, 8'h02, 1'b1});
    @(posedge clk); #1;

    // REQUIRE_CHECK=1, ERR_CNT_W=2 instance
    sel = 1'b1;
    frm = '{8'h01, 8'h02, 8'h03, 8'h04}; send_frame(100);
    chk("t5_4byte_err", {61'd0, b_frame_err, b_err_count}, {61'd0, 1'b1, 2'd1});
    chk("t5_no_out",    {63'd0, b_out_valid}, 64'd0);
    frm = '{8'h05, 8'h06}; send_frame(100);
    frm = '{8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C}; send_frame(100);
    chk("t5_cnt3", {62'd0, b_err_count}, 64'd3);
    frm = '{8'h0D}; send_frame(100);
    frm = '{8'h0E, 8'h0F, 8'h10, 8'h11}; send_frame(100);
    chk("t5_sat", {61'd0, b_frame_err, b_err_count}, {61'd0, 1'b1, 2'd3});
    frm = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A}; send_frame(100);
    chk("t5_good", {23'd0, b_out_valid, b_out_id, b_out_ic, b_out_r}, {23'd0, 1'b1, 32'h12345678, 8'h9A, 1'b1});
    @(posedge clk); #1 sel = 1'b0;

    // Reset while a word is held and a frame is partial
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35}; send_frame(0);
    send_byte(8'h41, 1'b0, 0); send_byte(8'h42, 1'b0, 0); send_byte(8'h43, 1'b0, 0);
    in_valid = 1'b0; mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", {63'd0, a_out_valid}, 64'd0);
    chk("t6_cnt",   {55'd0, a_frame_err, a_err_count}, 64'd0);
    chk("t6_ready_id", {31'd0, a_in_ready, a_out_id}, {31'd0, 1'b1, 32'd0});
    @(posedge clk); #1 rst_n = 1'b1; mon_en = 1'b1;
    frm = '{8'h5A, 8'hC3, 8'h0F, 8'hF0, 8'h99}; send_frame(100);
    chk("t6_after", {23'd0, a_out_valid, a_out_id, a_out_ic, a_out_r}, {23'd0, 1'b1, 32'h5AC30FF0, 8'h99, 1'b1});
    @(posedge clk); #1;

    // Randomized frames with random backpressure
    got_q.delete(); exp_q.delete(); pulses = 0; exp_errs = 0;
    for (int f = 0; f < 40; f++) begin
      int sel_len, len;
      sel_len = $urandom_range(0, 9);
      if (sel_len < 4)      len = 4;
      else if (sel_len < 7) len = 5;
      else if (sel_len == 7) len = $urandom_range(1, 3);
      else if (sel_len == 8) len = $urandom_range(6, 9);
      else len = 2;
      frm.delete();
      for (int i = 0; i < len; i++) frm.push_back(8'($urandom));
      model_frame();
      send_frame(60);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        out_ready = ($urandom_range(0, 99) < 60);
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rand_words", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("rand_word%0d", i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    chk("rand_pulses", pulses, exp_errs);
    chk("rand_errcnt", {56'd0, a_err_count}, (exp_errs > 255) ? 64'd255 : 64'(exp_errs));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
